uart_tx_fifo: RTL and testbench

- Byte buffer and handshake sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from the producer (command decoder, message ROM sequencer) in single-cycle writes and stores them in a circular FIFO.
- Presents one byte at a time to the transmitter, holding it stable for the full serial frame.
- Pops the next byte only after the transmitter reports frame completion.

---
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and frame sequencer feeding the UART transmitter.
// One byte is presented per frame; the next pops only after completion.
module uart_tx_fifo #(
    parameter int p_DEPTH  = 16,
    parameter int p_ADDR_W = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Wr_En,
    input  logic [7:0]          i_Wr_Byte,
    output logic                o_Full,
    output logic                o_Empty,
    output logic [p_ADDR_W:0]   o_Count,
    output logic                o_Overflow,
    input  logic                i_Clr_Overflow,
    output logic [7:0]          o_Tx_Byte,
    output logic                o_Tx_Ready,
    input  logic                i_Tx_Completed,
    output logic                o_Busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [p_ADDR_W:0] DEPTH_C = (p_ADDR_W + 1)'(p_DEPTH);

    logic [7:0]          mem [p_DEPTH];
    logic [p_ADDR_W-1:0] wr_ptr;
    logic [p_ADDR_W-1:0] rd_ptr;
    logic [p_ADDR_W:0]   count;
    state_t              state;

    logic full;
    logic empty;
    logic wr_ok;
    logic pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign wr_ok = i_Wr_En && !full;
    assign pop   = (state == IDLE) && !empty;

    assign o_Full  = full;
    assign o_Empty = empty;
    assign o_Count = count;
    assign o_Busy  = (state != IDLE) || !empty;

    always_ff @(posedge i_Clk) begin
        if (wr_ok && !i_Rst) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            o_Tx_Byte  <= 8'h00;
            o_Tx_Ready <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_ok && pop) begin
                count <= count - 1'b1;
            end

            // A rejected write beats a same-cycle clear.
            if (i_Wr_En && full) begin
                o_Overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                o_Overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        o_Tx_Byte  <= mem[rd_ptr];
                        o_Tx_Ready <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (i_Tx_Completed) begin
                        o_Tx_Ready <= 1'b0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue model, transmitter model,
// and directed scenarios with literal expectations.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int FRAME = 40;

    logic       clk = 0;
    logic       rst = 1;
    logic       wr_en = 0;
    logic [7:0] wr_byte = 0;
    logic       clr_ovf = 0;
    logic       done_man = 0;
    logic       done_auto = 0;
    logic       tx_completed;
    logic       full, empty, ovf, tx_ready, busy;
    logic [7:0] tx_byte;
    logic [4:0] count;

    assign tx_completed = done_man | done_auto;

    always #5 clk = ~clk;

    uart_tx_fifo #(.p_DEPTH(DEPTH), .p_ADDR_W(4)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Wr_En(wr_en),
        .i_Wr_Byte(wr_byte),
        .o_Full(full),
        .o_Empty(empty),
        .o_Count(count),
        .o_Overflow(ovf),
        .i_Clr_Overflow(clr_ovf),
        .o_Tx_Byte(tx_byte),
        .o_Tx_Ready(tx_ready),
        .i_Tx_Completed(tx_completed),
        .o_Busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stored bytes as a queue plus the frame phase.
    logic [7:0] m_q[$];
    int         m_phase = 0;
    logic [7:0] m_byte = 0;
    bit         m_ready = 0;
    bit         m_ovf = 0;
    bit         started = 0;
    bit         m_was_full;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_byte  = 0;
            m_ready = 0;
            m_ovf   = 0;
            started = 1;
        end else begin
            m_was_full = (m_q.size() == DEPTH);
            if (wr_en && m_was_full) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            case (m_phase)
                0: if (m_q.size() != 0) begin
                    m_byte  = m_q.pop_front();
                    m_ready = 1;
                    m_phase = 1;
                end
                1: if (tx_completed) begin
                    m_ready = 0;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            if (wr_en && !m_was_full) m_q.push_back(wr_byte);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("tx_ready", tx_ready, m_ready);
            chk("tx_byte", tx_byte, m_byte);
            chk("count", count, m_q.size());
            chk("empty", empty, int'(m_q.size() == 0));
            chk("full", full, int'(m_q.size() == DEPTH));
            chk("overflow", ovf, m_ovf);
            chk("busy", busy, int'(m_phase != 0 || m_q.size() != 0));
        end
    end

    // Transmitter model: FRAME cycles per byte, then a one-cycle completion.
    bit         tx_auto = 0;
    bit         gap_chk = 0;
    bit         after_done = 0;
    int         fcnt = 0;
    int         lowcnt = 0;
    int         gaps = 0;
    logic [7:0] fbyte = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        done_auto = 0;
        if (!tx_auto || rst) begin
            fcnt = 0;
            after_done = 0;
        end else if (tx_ready) begin
            if (after_done) begin
                if (gap_chk) begin
                    chk("gap_low_cycles", lowcnt, 2);
                    gaps++;
                end
                after_done = 0;
            end
            if (fcnt == 0) fbyte = tx_byte;
            else chk("frame_stable", tx_byte, fbyte);
            fcnt++;
            if (fcnt == FRAME) begin
                done_auto = 1;
                rxq.push_back(fbyte);
                fcnt = 0;
                after_done = 1;
                lowcnt = 0;
            end
        end else if (after_done) begin
            lowcnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1;
        wr_byte = b;
    endtask

    task automatic rel();
        @(negedge clk);
        wr_en = 0;
        clr_ovf = 0;
        done_man = 0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_man = 1;
        @(negedge clk);
        done_man = 0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and single byte
        do_reset();
        chk("rst_ready", tx_ready, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        put(8'hA5);
        rel();
        chk("t1_count1", count, 1);
        chk("t1_ready0", tx_ready, 0);
        cyc(1);
        chk("t1_byte", tx_byte, 8'hA5);
        chk("t1_ready1", tx_ready, 1);
        chk("t1_count0", count, 0);
        cyc(5);
        chk("t1_hold", tx_byte, 8'hA5);
        pulse_done();
        chk("t1_fall", tx_ready, 0);
        cyc(3);
        chk("t1_idle", busy, 0);

        // Burst with transmitter
        do_reset();
        rxq.delete();
        gaps = 0;
        tx_auto = 1;
        gap_chk = 1;
        for (int i = 1; i <= 5; i++) put(8'(i));
        rel();
        wait_idle(2000, "t2_drain");
        gap_chk = 0;
        tx_auto = 0;
        chk("t2_frames", rxq.size(), 5);
        chk("t2_gaps", gaps, 4);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            chk("t2_order", rxq[i], i + 1);

        // Fill and overflow
        do_reset();
        for (int i = 0; i < 17; i++) put(8'(8'h10 + i));
        rel();
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        chk("t3_ready", tx_ready, 1);
        chk("t3_byte", tx_byte, 8'h10);
        put(8'hEE);
        put(8'hEF);
        rel();
        chk("t3_ovf", ovf, 1);
        chk("t3_count_kept", count, 16);
        @(negedge clk);
        clr_ovf = 1;
        rel();
        chk("t3_ovf_clr", ovf, 0);
        @(negedge clk);
        wr_en = 1;
        wr_byte = 8'hEE;
        clr_ovf = 1;
        rel();
        chk("t3_set_wins", ovf, 1);
        rxq.delete();
        tx_auto = 1;
        wait_idle(3000, "t3_drain");
        tx_auto = 0;
        chk("t3_frames", rxq.size(), 17);
        for (int i = 0; i < 17 && i < rxq.size(); i++)
            chk("t3_order", rxq[i], 8'h10 + i);

        // Wrap-around, 40 bytes
        do_reset();
        rxq.delete();
        tx_auto = 1;
        begin
            int i = 0;
            int guard = 0;
            while (i < 40 && guard < 5000) begin
                @(negedge clk);
                guard++;
                if (!full) begin
                    wr_en = 1;
                    wr_byte = 8'(i * 3);
                    i++;
                end else begin
                    wr_en = 0;
                end
            end
            rel();
            chk("t4_written", i, 40);
        end
        wait_idle(3000, "t4_drain");
        tx_auto = 0;
        chk("t4_frames", rxq.size(), 40);
        for (int i = 0; i < 40 && i < rxq.size(); i++)
            chk("t4_order", rxq[i], (i * 3) % 256);

        // Simultaneous write and pop
        do_reset();
        put(8'h50);
        put(8'h51);
        put(8'h52);
        put(8'h53);
        rel();
        chk("t5_count3", count, 3);
        chk("t5_first", tx_byte, 8'h50);
        pulse_done();
        put(8'h54);
        rel();
        chk("t5_count_same", count, 3);
        chk("t5_ready", tx_ready, 1);
        chk("t5_oldest", tx_byte, 8'h51);
        rxq.delete();
        tx_auto = 1;
        wait_idle(2000, "t5_drain");
        tx_auto = 0;
        chk("t5_frames", rxq.size(), 4);
        for (int i = 0; i < 4 && i < rxq.size(); i++)
            chk("t5_order", rxq[i], 8'h51 + i);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 6; i++) put(8'(8'h60 + i));
        rel();
        chk("t6_count5", count, 5);
        chk("t6_sending", tx_ready, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t6_ready0", tx_ready, 0);
        chk("t6_count0", count, 0);
        chk("t6_empty", empty, 1);
        pulse_done();
        cyc(3);
        chk("t6_stray_ready", tx_ready, 0);
        chk("t6_stray_count", count, 0);
        chk("t6_stray_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
